// File: rtl/bw_io_impctl_pkg.sv
// Shared types and helpers for the impedance-calibration controller.
// FSM state codes, step directions and thermometer encoding.
package bw_io_impctl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_LOCK   = 3'd4;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } dir_e;

    // Bit idx of the thermometer code for a binary leg count.
    function automatic logic therm_bit(input int code, input int idx);
        return idx < code;
    endfunction

endpackage

// File: rtl/bw_io_impctl_cal_fsm_if.sv
// Control/status bundle of the impedance-calibration controller.
// master drives requests and CSR traffic; slave is the controller.
interface bw_io_impctl_cal_fsm_if #(
    parameter int LEGS = 8,
    parameter int CW   = $clog2(LEGS + 1)
);
    logic            start;
    logic            above;
    logic            mode_pu;
    logic            upd_imped;
    logic            bypass;
    logic            we_csr;
    logic [CW-1:0]   from_csr;
    logic [LEGS-1:0] d;
    logic [LEGS-1:0] z;
    logic [CW-1:0]   to_csr;
    logic            busy;
    logic            done;
    logic            sat;

    modport master (
        output start, above, mode_pu, upd_imped,
        output bypass, we_csr, from_csr,
        input  d, z, to_csr, busy, done, sat
    );

    modport slave (
        input  start, above, mode_pu, upd_imped,
        input  bypass, we_csr, from_csr,
        output d, z, to_csr, busy, done, sat
    );
endinterface

// File: rtl/bw_io_impctl_avg.sv
// Comparator synchroniser and windowed ones counter.
// valid marks the last sample of the window; ones includes it.
module bw_io_impctl_avg
    import bw_io_impctl_pkg::*;
#(
    parameter  int AVG_LOG2 = 4,
    localparam int W        = AVG_LOG2 + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         above,
    input  logic         go,
    output logic         valid,
    output logic [W-1:0] ones
);
    localparam int N   = 1 << AVG_LOG2;
    localparam int CNW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic           s1;
    logic           s2;
    logic [CNW-1:0] cnt;
    logic [W-1:0]   acc;
    logic           last;

    assign last  = go && (cnt == CNW'(N - 1));
    assign valid = last;
    assign ones  = acc + W'(s2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            acc <= '0;
        end else begin
            s1 <= above;
            s2 <= s1;
            if (!go || last) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + CNW'(1);
                acc <= ones;
            end
        end
    end

endmodule

// File: rtl/bw_io_impctl_cal_fsm.sv
// Impedance-calibration controller: steps a replica leg code until the
// averaged comparator lands in the hysteresis band or the code saturates.
module bw_io_impctl_cal_fsm
    import bw_io_impctl_pkg::*;
#(
    parameter  int LEGS     = 8,
    parameter  int AVG_LOG2 = 4,
    parameter  int HYST     = 2,
    parameter  int SETTLE   = 4,
    localparam int CW       = $clog2(LEGS + 1)
) (
    input logic                   rclk,
    input logic                   hard_reset,
    bw_io_impctl_cal_fsm_if.slave bus
);
    localparam int N   = 1 << AVG_LOG2;
    localparam int W   = AVG_LOG2 + 1;
    localparam int SCW = $clog2(SETTLE + 1);
    localparam int HI  = N / 2 + HYST;
    localparam int LO  = N / 2 - HYST;
    localparam int MID = LEGS / 2;

    logic [2:0]    state;
    logic [SCW-1:0] cnt;
    logic [CW-1:0] code;
    logic [CW-1:0] app;
    logic [CW-1:0] csr;
    logic          mode;
    dir_e          prev;
    dir_e          req;
    logic [W-1:0]  ones_q;
    logic          sat_q;
    logic          av_valid;
    logic [W-1:0]  av_ones;
    logic          blocked;
    logic          dither;
    logic [CW-1:0] stepped;
    logic [CW-1:0] zsrc;

    bw_io_impctl_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk   (rclk),
        .rst   (hard_reset),
        .above (bus.above),
        .go    (state == S_SAMPLE),
        .valid (av_valid),
        .ones  (av_ones)
    );

    // Pullup replicas move the pad the other way per leg.
    always_comb begin
        req = DIR_NONE;
        if (int'(ones_q) >= HI)
            req = mode ? DIR_DN : DIR_UP;
        else if (int'(ones_q) <= LO)
            req = mode ? DIR_UP : DIR_DN;
    end

    assign blocked = (req == DIR_UP && code == CW'(LEGS)) ||
                     (req == DIR_DN && code == '0);
    assign dither  = (prev != DIR_NONE) && (req != prev);
    assign stepped = (req == DIR_UP) ? code + CW'(1) : code - CW'(1);

    always_ff @(posedge rclk or posedge hard_reset) begin
        if (hard_reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            code   <= CW'(MID);
            mode   <= 1'b0;
            prev   <= DIR_NONE;
            ones_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.start) begin
                    state <= S_SETTLE;
                    cnt   <= '0;
                    mode  <= bus.mode_pu;
                    prev  <= DIR_NONE;
                    sat_q <= 1'b0;
                end
                S_SETTLE: if (cnt == SCW'(SETTLE - 1)) begin
                    state <= S_SAMPLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + SCW'(1);
                end
                S_SAMPLE: if (av_valid) begin
                    ones_q <= av_ones;
                    state  <= S_DECIDE;
                end
                S_DECIDE: if (req == DIR_NONE) begin
                    state <= S_LOCK;
                end else if (blocked) begin
                    state <= S_LOCK;
                    sat_q <= 1'b1;
                end else begin
                    code  <= stepped;
                    prev  <= req;
                    state <= dither ? S_LOCK : S_SETTLE;
                end
                S_LOCK:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge hard_reset) begin
        if (hard_reset) begin
            app <= CW'(MID);
            csr <= CW'(MID);
        end else begin
            if (bus.upd_imped)
                app <= code;
            if (bus.we_csr)
                csr <= (bus.from_csr > CW'(LEGS)) ? CW'(LEGS) : bus.from_csr;
        end
    end

    assign zsrc = bus.bypass ? csr : app;

    for (genvar i = 0; i < LEGS; i++) begin : g_therm
        assign bus.d[i] = therm_bit(32'(code), i);
        assign bus.z[i] = therm_bit(32'(zsrc), i);
    end

    assign bus.to_csr = code;
    assign bus.busy   = (state == S_SETTLE) || (state == S_SAMPLE) ||
                        (state == S_DECIDE);
    assign bus.done   = (state == S_LOCK);
    assign bus.sat    = sat_q;

endmodule

// File: tb/tb_bw_io_impctl_cal_fsm.sv
// Randomised and directed bench for the calibration controller,
// with a per-code replica behaviour table and an abstract run model.
module tb_bw_io_impctl_cal_fsm;
    localparam int LEGS = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    // Replica behaviour per code: 0 below ref, 1 above ref, 2 balanced.
    int   beh[9];
    bit   rep_en;
    bit   phase;
    int   cal_code, app_code, csr_code;
    int   exp_seq[$];

    bw_io_impctl_cal_fsm_if #(.LEGS(LEGS)) bif ();

    bw_io_impctl_cal_fsm #(
        .LEGS(LEGS), .AVG_LOG2(2), .HYST(1), .SETTLE(2)
    ) dut (
        .rclk       (clk),
        .hard_reset (rst),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    function automatic int therm(int c);
        return (1 << c) - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        phase = ~phase;
        if (rep_en) begin
            case (beh[bif.to_csr])
                0:       bif.above = 1'b0;
                1:       bif.above = 1'b1;
                default: bif.above = phase;
            endcase
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.start = 0; bif.above = 0; bif.mode_pu = 0;
        bif.upd_imped = 0; bif.bypass = 0; bif.we_csr = 0;
        bif.from_csr = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        cal_code = 4; app_code = 4; csr_code = 4;
    endtask

    // Whole-run outcome from the stepping rules alone.
    task automatic model_run(input bit mode, input int c0,
                             output int fin, output bit s, output int nd);
        int c, prev, dir;
        c = c0; prev = 0; nd = 0; s = 0;
        exp_seq.delete();
        for (int k = 0; k < 40; k++) begin
            nd++;
            if (beh[c] == 2) break;
            dir = (beh[c] == 1) ? (mode ? -1 : 1) : (mode ? 1 : -1);
            if (c + dir < 0 || c + dir > LEGS) begin
                s = 1;
                break;
            end
            c += dir;
            exp_seq.push_back(c);
            if (prev != 0 && dir != prev) break;
            prev = dir;
        end
        fin = c;
    endtask

    task automatic run_cal(input string name, input bit mode,
                           input bit inj_start, input bit inj_csr);
        int fin, nd, c, last;
        bit s;
        int oc[$], ot[$];
        logic [7:0] e;
        int v;
        model_run(mode, cal_code, fin, s, nd);
        bif.mode_pu = mode;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        c = 1;
        vectors++;
        if (bif.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_busy: got %b want 1", name, bif.busy);
        end
        last = cal_code;
        while (c < 400) begin
            if (int'(bif.to_csr) != last) begin
                last = int'(bif.to_csr);
                oc.push_back(last);
                ot.push_back(c);
            end
            if (bif.done === 1'b1) break;
            if (inj_start && c == 3) bif.start = 1'b1;
            if (inj_csr && c == 4) begin
                v = $urandom_range(0, 15);
                bif.we_csr = 1'b1;
                bif.from_csr = 4'(v);
                csr_code = (v > LEGS) ? LEGS : v;
            end
            tick();
            bif.start = 1'b0;
            bif.we_csr = 1'b0;
            c++;
        end
        vectors++;
        if (c != 7 * nd + 1) begin
            miscompares++;
            $display("FAIL %s_done_cycle: got %0d want %0d", name, c, 7 * nd + 1);
        end
        vectors++;
        if (oc.size() != exp_seq.size()) begin
            miscompares++;
            $display("FAIL %s_steps: got %0d want %0d", name, oc.size(), exp_seq.size());
        end else begin
            foreach (exp_seq[i]) begin
                vectors++;
                if (oc[i] != exp_seq[i] || ot[i] != 7 * (i + 1) + 1) begin
                    miscompares++;
                    $display("FAIL %s_step%0d: got %0d@%0d want %0d@%0d",
                             name, i, oc[i], ot[i], exp_seq[i], 7 * (i + 1) + 1);
                end
            end
        end
        vectors++;
        if (bif.sat !== s || int'(bif.to_csr) != fin) begin
            miscompares++;
            $display("FAIL %s_result: got sat=%b code=%0d want sat=%b code=%0d",
                     name, bif.sat, bif.to_csr, s, fin);
        end
        e = 8'(therm(fin));
        vectors++;
        if (bif.d !== e) begin
            miscompares++;
            $display("FAIL %s_d: got %h want %h", name, bif.d, e);
        end
        e = 8'(therm(bif.bypass ? csr_code : app_code));
        vectors++;
        if (bif.z !== e) begin
            miscompares++;
            $display("FAIL %s_z_hold: got %h want %h", name, bif.z, e);
        end
        tick();
        vectors++;
        if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after: got done=%b busy=%b want 0 0",
                     name, bif.done, bif.busy);
        end
        cal_code = fin;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bif.d !== 8'h0F || bif.z !== 8'h0F) begin
            miscompares++;
            $display("FAIL reset_dz: got %h %h want 0f 0f", bif.d, bif.z);
        end
        vectors++;
        if (bif.to_csr !== 4'd4 || bif.busy !== 1'b0 ||
            bif.done !== 1'b0 || bif.sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got code=%0d busy=%b done=%b sat=%b want 4 0 0 0",
                     bif.to_csr, bif.busy, bif.done, bif.sat);
        end
    endtask

    task automatic test_pulldown_sat();
        do_reset();
        foreach (beh[i]) beh[i] = 1;
        run_cal("pd_sat", 1'b0, 1'b0, 1'b0);
        bif.upd_imped = 1'b1;
        tick();
        bif.upd_imped = 1'b0;
        app_code = cal_code;
        vectors++;
        if (bif.z !== 8'hFF) begin
            miscompares++;
            $display("FAIL pd_upd_z: got %h want ff", bif.z);
        end
    endtask

    task automatic test_pullup_sat();
        do_reset();
        foreach (beh[i]) beh[i] = 1;
        run_cal("pu_sat", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_dither();
        do_reset();
        foreach (beh[i]) beh[i] = (i < 6) ? 1 : 0;
        run_cal("dither", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_band_lock();
        do_reset();
        foreach (beh[i]) beh[i] = 2;
        run_cal("band", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_bypass_csr();
        do_reset();
        bif.bypass = 1'b1;
        bif.we_csr = 1'b1;
        bif.from_csr = 4'd12;
        tick();
        vectors++;
        if (bif.z !== 8'hFF) begin
            miscompares++;
            $display("FAIL bypass_clamp: got %h want ff", bif.z);
        end
        bif.from_csr = 4'd3;
        tick();
        bif.we_csr = 1'b0;
        vectors++;
        if (bif.z !== 8'h07 || bif.to_csr !== 4'd4) begin
            miscompares++;
            $display("FAIL bypass_write: got z=%h code=%0d want 07 4", bif.z, bif.to_csr);
        end
        bif.bypass = 1'b0;
        #1;
        vectors++;
        if (bif.z !== 8'h0F) begin
            miscompares++;
            $display("FAIL bypass_off: got %h want 0f", bif.z);
        end
    endtask

    task automatic test_hard_reset_mid();
        do_reset();
        foreach (beh[i]) beh[i] = 1;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (bif.busy !== 1'b0 || bif.to_csr !== 4'd4 ||
            bif.d !== 8'h0F || bif.z !== 8'h0F) begin
            miscompares++;
            $display("FAIL hreset_mid: got busy=%b code=%0d d=%h z=%h want 0 4 0f 0f",
                     bif.busy, bif.to_csr, bif.d, bif.z);
        end
        tick();
        rst = 1'b0;
        repeat (10) tick();
        vectors++;
        if (bif.busy !== 1'b0 || bif.to_csr !== 4'd4) begin
            miscompares++;
            $display("FAIL hreset_idle: got busy=%b code=%0d want 0 4",
                     bif.busy, bif.to_csr);
        end
        cal_code = 4; app_code = 4; csr_code = 4;
    endtask

    task automatic test_random_runs();
        logic [7:0] e;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            foreach (beh[i]) beh[i] = $urandom_range(0, 2);
            run_cal($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                    1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                bif.upd_imped = 1'b1;
                tick();
                bif.upd_imped = 1'b0;
                app_code = cal_code;
            end
            bif.bypass = 1'($urandom_range(0, 1));
            #1;
            e = 8'(therm(bif.bypass ? csr_code : app_code));
            vectors++;
            if (bif.z !== e) begin
                miscompares++;
                $display("FAIL rnd%0d_z: got %h want %h", r, bif.z, e);
            end
            bif.bypass = 1'b0;
        end
    endtask

    initial begin
        rep_en = 1'b1;
        phase = 1'b0;
        foreach (beh[i]) beh[i] = 0;
        test_reset();
        test_pulldown_sat();
        test_pullup_sat();
        test_dither();
        test_band_lock();
        test_bypass_csr();
        test_hard_reset_mid();
        test_random_runs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
